// File: rtl/picorv32_mem_arbiter_pkg.sv
// Shared definitions for the picorv32 memory arbiter: FSM states, limits, round-robin pick.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package picorv32_arb_pkg;

    localparam int MAX_PORTS = 8;
    localparam int WDT_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    // First requester at or after ptr, wrapping at MAX_PORTS. Unused upper
    // request bits are zero, so wrapping at 8 equals wrapping at NUM_PORTS.
    function automatic logic [2:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                           input logic [2:0]           ptr);
        logic [2:0] idx;
        logic [2:0] pick;
        logic       found;
        found = 1'b0;
        pick  = 3'd0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            idx = ptr + 3'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/picorv32_mem_arbiter_if.sv
// picorv32 native memory bus bundle, N lanes packed side by side, one shared rdata.
// Latency: wires only.
// Backpressure: ready from the slave side completes the pending valid of its lane.
interface picorv32_mem_arbiter_if #(
    parameter int N = 1
);
    logic [N-1:0]    valid;
    logic [N-1:0]    instr;
    logic [32*N-1:0] addr;
    logic [32*N-1:0] wdata;
    logic [4*N-1:0]  wstrb;
    logic [N-1:0]    ready;
    logic [31:0]     rdata;

    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/picorv32_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: lowest requester at or after ptr, circular.
// Latency: 0 cycles.
// Backpressure: none; the caller decides when a pick is consumed.
module picorv32_rr_arbiter
    import picorv32_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [2:0]           ptr_i,
    output logic [2:0]           gnt_idx_o,
    output logic                 any_req_o
);

    logic [MAX_PORTS-1:0] req_pad;

    // Zero-extend the request vector so the picker always scans eight lanes.
    always_comb begin
        req_pad                = '0;
        req_pad[NUM_PORTS-1:0] = req_i;
        gnt_idx_o              = rr_pick(req_pad, ptr_i);
        any_req_o              = |req_i;
    end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Merges NUM_PORTS picorv32 memory masters onto one downstream port, round-robin, optional watchdog.
// Latency: request->mem_valid 1 cycle, mem_ready->up_ready 1 cycle; 3 cycles/transfer at zero wait.
// Backpressure: one transfer in flight; other masters wait in IDLE; TIMEOUT>0 aborts stalls with err.
module picorv32_mem_arbiter
    import picorv32_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int TIMEOUT   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    picorv32_mem_arbiter_if.slave  up,
    picorv32_mem_arbiter_if.master mem,
    output logic                   err_valid,
    output logic [2:0]             err_port
);

    localparam logic [WDT_W-1:0] WDT_LAST = (TIMEOUT > 0) ? WDT_W'(TIMEOUT - 1) : '0;

    arb_state_e           state_q, state_d;
    logic [2:0]           grant_q, grant_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [WDT_W-1:0]     wdt_q, wdt_d;
    logic                 mem_valid_q, mem_valid_d;
    logic                 mem_instr_q, mem_instr_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;
    logic [3:0]           mem_wstrb_q, mem_wstrb_d;
    logic [NUM_PORTS-1:0] up_ready_q, up_ready_d;
    logic [31:0]          up_rdata_q, up_rdata_d;
    logic                 err_valid_q, err_valid_d;
    logic [2:0]           err_port_q, err_port_d;

    logic [2:0]           gnt_idx;
    logic                 any_req;
    logic                 timeout_hit;
    logic [2:0]           rr_next;

    picorv32_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr (
        .req_i     (up.valid),
        .ptr_i     (rr_ptr_q),
        .gnt_idx_o (gnt_idx),
        .any_req_o (any_req)
    );

    // Next-state, capture, completion and watchdog decisions.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        wdt_d       = wdt_q;
        mem_valid_d = mem_valid_q;
        mem_instr_d = mem_instr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        up_ready_d  = '0;
        up_rdata_d  = up_rdata_q;
        err_valid_d = 1'b0;
        err_port_d  = '0;

        timeout_hit = (TIMEOUT > 0) && (wdt_q == WDT_LAST);
        rr_next     = (grant_q == 3'(NUM_PORTS - 1)) ? 3'd0 : grant_q + 3'd1;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d     = gnt_idx;
                    mem_valid_d = 1'b1;
                    wdt_d       = '0;
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (gnt_idx == 3'(i)) begin
                            mem_instr_d = up.instr[i];
                            mem_addr_d  = up.addr[32*i +: 32];
                            mem_wdata_d = up.wdata[32*i +: 32];
                            mem_wstrb_d = up.wstrb[4*i +: 4];
                        end
                    end
                    state_d = BUSY;
                end
            end
            BUSY: begin
                wdt_d = wdt_q + 1'b1;
                // A ready arriving on the last watchdog cycle still completes cleanly.
                if (mem.ready[0] || timeout_hit) begin
                    mem_valid_d = 1'b0;
                    rr_ptr_d    = rr_next;
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        up_ready_d[i] = (grant_q == 3'(i));
                    end
                    if (mem.ready[0]) begin
                        up_rdata_d = mem.rdata;
                    end else begin
                        up_rdata_d  = '0;
                        err_valid_d = 1'b1;
                        err_port_d  = grant_q;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                // Dead cycle so the finished master can drop valid before re-arbitration.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer with no completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            wdt_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            up_ready_q  <= '0;
            up_rdata_q  <= '0;
            err_valid_q <= 1'b0;
            err_port_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            wdt_q       <= wdt_d;
            mem_valid_q <= mem_valid_d;
            mem_instr_q <= mem_instr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            up_ready_q  <= up_ready_d;
            up_rdata_q  <= up_rdata_d;
            err_valid_q <= err_valid_d;
            err_port_q  <= err_port_d;
        end
    end

    assign mem.valid = mem_valid_q;
    assign mem.instr = mem_instr_q;
    assign mem.addr  = mem_addr_q;
    assign mem.wdata = mem_wdata_q;
    assign mem.wstrb = mem_wstrb_q;
    assign up.ready  = up_ready_q;
    assign up.rdata  = up_rdata_q;
    assign err_valid = err_valid_q;
    assign err_port  = err_port_q;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench for picorv32_mem_arbiter: a 2-port instance without watchdog and a 4-port one with TIMEOUT=8.
// Latency: expected cycle counts are hand-derived per vector.
// Backpressure: memory models add configurable wait states or stall indefinitely.
module tb_picorv32_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic err_v_a, err_v_b;
    logic [2:0] err_p_a, err_p_b;

    picorv32_mem_arbiter_if #(.N(2)) up_a ();
    picorv32_mem_arbiter_if #(.N(1)) dn_a ();
    picorv32_mem_arbiter_if #(.N(4)) up_b ();
    picorv32_mem_arbiter_if #(.N(1)) dn_b ();

    picorv32_mem_arbiter #(.NUM_PORTS(2), .TIMEOUT(0)) dut_a (
        .clk(clk), .reset(rst_a), .up(up_a), .mem(dn_a), .err_valid(err_v_a), .err_port(err_p_a));

    picorv32_mem_arbiter #(.NUM_PORTS(4), .TIMEOUT(8)) dut_b (
        .clk(clk), .reset(rst_b), .up(up_b), .mem(dn_b), .err_valid(err_v_b), .err_port(err_p_b));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: ready after lat wait cycles unless stalled; rdata is junk when not ready.
    int lat_a = 0, lat_b = 0, wcnt_a = 0, wcnt_b = 0;
    bit stall_a = 1'b0, stall_b = 1'b0;
    logic [31:0] rval_a = '0, rval_b = '0;

    always @(negedge clk) begin
        if (dn_a.valid[0] === 1'b1 && !stall_a && wcnt_a >= lat_a) begin
            dn_a.ready <= 1'b1;
            dn_a.rdata <= rval_a;
        end else begin
            dn_a.ready <= 1'b0;
            dn_a.rdata <= 32'h0BAD_0BAD;
            wcnt_a     <= (dn_a.valid[0] === 1'b1) ? wcnt_a + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (dn_b.valid[0] === 1'b1 && !stall_b && wcnt_b >= lat_b) begin
            dn_b.ready <= 1'b1;
            dn_b.rdata <= rval_b;
        end else begin
            dn_b.ready <= 1'b0;
            dn_b.rdata <= 32'h0BAD_0BAD;
            wcnt_b     <= (dn_b.valid[0] === 1'b1) ? wcnt_b + 1 : 0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_rdy_a(input int budget, output logic [1:0] r, output int at);
        r  = '0;
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (up_a.ready != 0) begin
                r  = up_a.ready;
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("wait_ready_a", 64'd0, 64'd1);
    endtask

    task automatic wait_rdy_b(input int budget, output logic [3:0] r, output int at);
        r  = '0;
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (up_b.ready != 0) begin
                r  = up_b.ready;
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("wait_ready_b", 64'd0, 64'd1);
    endtask

    typedef struct {
        int          port;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        bit          stall;
        logic [31:0] mrdata;
        int          exp_k;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt [5];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no end expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [1:0] ra;
        logic [3:0] rb;
        int at0, at1, c1, got_k, prev;
        int cnt [4];
        bit spurious;

        vt[0] = '{2, 1'b0, 32'h2000_0004, 32'h1234_5678, 4'b0110, 0, 1'b0, 32'hCAFE_0002, 2, 32'hCAFE_0002, 1'b0};
        vt[1] = '{3, 1'b1, 32'h0000_0400, 32'h0000_0000, 4'b0000, 7, 1'b0, 32'h3333_7777, 9, 32'h3333_7777, 1'b0};
        vt[2] = '{0, 1'b0, 32'h8000_0010, 32'hA5A5_5A5A, 4'b1111, 0, 1'b0, 32'h0000_0001, 2, 32'h0000_0001, 1'b0};
        vt[3] = '{1, 1'b0, 32'h0000_1000, 32'h0000_0000, 4'b0000, 0, 1'b1, 32'hFFFF_FFFF, 9, 32'h0000_0000, 1'b1};
        vt[4] = '{1, 1'b1, 32'h0000_1004, 32'h0000_0000, 4'b0000, 3, 1'b0, 32'h1111_2222, 5, 32'h1111_2222, 1'b0};

        rst_a = 1'b1; rst_b = 1'b1;
        up_a.valid = '0; up_a.instr = '0; up_a.addr = '0; up_a.wdata = '0; up_a.wstrb = '0;
        up_b.valid = '0; up_b.instr = '0; up_b.addr = '0; up_b.wdata = '0; up_b.wstrb = '0;
        repeat (3) @(negedge clk);

        chk("rst_b_mem_valid", dn_b.valid, 0);
        chk("rst_b_mem_instr", dn_b.instr, 0);
        chk("rst_b_mem_addr",  dn_b.addr, 0);
        chk("rst_b_mem_wdata", dn_b.wdata, 0);
        chk("rst_b_mem_wstrb", dn_b.wstrb, 0);
        chk("rst_b_up_ready",  up_b.ready, 0);
        chk("rst_b_up_rdata",  up_b.rdata, 0);
        chk("rst_b_err_valid", err_v_b, 0);
        chk("rst_b_err_port",  err_p_b, 0);
        chk("rst_a_mem_valid", dn_a.valid, 0);
        chk("rst_a_up_ready",  up_a.ready, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // ---- 2-port: contention from rr_ptr=0 with zero-wait memory
        lat_a = 0; rval_a = 32'h0000_00A0;
        up_a.addr  = {32'h0000_0204, 32'h0000_0200};
        up_a.valid = 2'b11;
        wait_rdy_a(20, ra, at0);
        chk("cont_first", ra, 2'b01);
        up_a.valid[0] = 1'b0;
        wait_rdy_a(20, ra, at1);
        chk("cont_second", ra, 2'b10);
        chk("cont_gap", at1 - at0, 3);
        up_a.valid[1] = 1'b0;
        @(negedge clk);
        // rr_ptr must have wrapped to 0: port 0 wins again
        up_a.valid = 2'b11;
        wait_rdy_a(20, ra, at0);
        chk("cont_ptr_wrap", ra, 2'b01);
        up_a.valid[0] = 1'b0;
        wait_rdy_a(20, ra, at1);
        chk("cont_ptr_second", ra, 2'b10);
        up_a.valid[1] = 1'b0;
        @(negedge clk);

        // ---- 2-port: single read, memory answers one cycle late
        lat_a = 1; rval_a = 32'hDEAD_BEEF;
        up_a.addr  = {32'h0000_0000, 32'h0000_1000};
        up_a.wstrb = '0;
        up_a.valid = 2'b01;
        @(negedge clk);
        c1 = cyc;
        chk("rd_mem_valid", dn_a.valid, 1);
        chk("rd_mem_addr",  dn_a.addr, 32'h0000_1000);
        chk("rd_mem_wstrb", dn_a.wstrb, 0);
        wait_rdy_a(10, ra, at0);
        chk("rd_up_ready", ra, 2'b01);
        chk("rd_latency", at0 - c1, 2);
        chk("rd_up_rdata", up_a.rdata, 32'hDEAD_BEEF);
        up_a.valid = '0;
        @(negedge clk);
        chk("rd_ready_pulse", up_a.ready, 0);
        chk("rd_rdata_held", up_a.rdata, 32'hDEAD_BEEF);

        // ---- 2-port, watchdog disabled: a stall never completes or errors
        stall_a = 1'b1;
        up_a.valid = 2'b10;
        spurious = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (up_a.ready != 0 || err_v_a) spurious = 1'b1;
        end
        chk("nowdt_no_completion", spurious, 0);
        chk("nowdt_still_busy", dn_a.valid, 1);
        rst_a = 1'b1;
        up_a.valid = '0;
        stall_a = 1'b0;
        @(negedge clk);
        chk("nowdt_reset_drop", dn_a.valid, 0);
        rst_a = 1'b0;

        // ---- 4-port fairness: all ports request continuously for 12 transfers
        lat_b = 0; stall_b = 1'b0; rval_b = 32'h5555_0000;
        up_b.addr  = {32'h4000_000C, 32'h4000_0008, 32'h4000_0004, 32'h4000_0000};
        up_b.valid = 4'hF;
        for (int p = 0; p < 4; p++) cnt[p] = 0;
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            wait_rdy_b(20, rb, at0);
            chk("fair_order", rb, 4'b0001 << (i % 4));
            if (i > 0) chk("fair_gap", at0 - prev, 3);
            prev = at0;
            for (int p = 0; p < 4; p++) if (rb[p]) cnt[p]++;
        end
        up_b.valid = '0;
        for (int p = 0; p < 4; p++) chk("fair_count", cnt[p], 3);
        @(negedge clk);

        // ---- 4-port table: single requests with varied wait states and timeout
        for (int i = 0; i < 5; i++) begin
            lat_b   = vt[i].lat;
            stall_b = vt[i].stall;
            rval_b  = vt[i].mrdata;
            up_b.addr  = '0;
            up_b.wdata = '0;
            up_b.wstrb = '0;
            up_b.addr[32*vt[i].port +: 32] = vt[i].addr;
            up_b.wdata[32*vt[i].port +: 32] = vt[i].wdata;
            up_b.wstrb[4*vt[i].port +: 4] = vt[i].wstrb;
            up_b.instr = vt[i].instr ? (4'b0001 << vt[i].port) : 4'b0000;
            up_b.valid = 4'b0001 << vt[i].port;
            got_k = 0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    chk("vec_mem_valid", dn_b.valid, 1);
                    chk("vec_mem_addr",  dn_b.addr, vt[i].addr);
                    chk("vec_mem_wdata", dn_b.wdata, vt[i].wdata);
                    chk("vec_mem_wstrb", dn_b.wstrb, vt[i].wstrb);
                    chk("vec_mem_instr", dn_b.instr, vt[i].instr);
                end
                if (up_b.ready != 0) begin
                    got_k = k;
                    break;
                end
            end
            chk("vec_ready_cycle", got_k, vt[i].exp_k);
            chk("vec_up_ready", up_b.ready, 4'b0001 << vt[i].port);
            chk("vec_up_rdata", up_b.rdata, vt[i].exp_rdata);
            chk("vec_err_valid", err_v_b, vt[i].exp_err);
            chk("vec_err_port", err_p_b, vt[i].exp_err ? vt[i].port : 0);
            chk("vec_mem_dropped", dn_b.valid, 0);
            up_b.valid = '0;
            @(negedge clk);
            chk("vec_ready_pulse", up_b.ready, 0);
            chk("vec_err_pulse", err_v_b, 0);
            chk("vec_rdata_held", up_b.rdata, vt[i].exp_rdata);
        end

        // ---- 4-port: reset during a stalled transfer (rr_ptr is 2 here)
        stall_b = 1'b1;
        up_b.addr  = {32'h0, 32'h0000_3000, 32'h0, 32'h0000_0300};
        up_b.wstrb = '0;
        up_b.instr = '0;
        up_b.valid = 4'b0100;
        repeat (4) @(negedge clk);
        chk("rstmid_busy", dn_b.valid, 1);
        rst_b = 1'b1;
        @(negedge clk);
        chk("rstmid_mem_valid", dn_b.valid, 0);
        chk("rstmid_mem_addr",  dn_b.addr, 0);
        chk("rstmid_up_ready",  up_b.ready, 0);
        chk("rstmid_up_rdata",  up_b.rdata, 0);
        chk("rstmid_err_valid", err_v_b, 0);
        rst_b = 1'b0;
        up_b.valid = '0;
        stall_b = 1'b0;
        spurious = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (up_b.ready != 0 || err_v_b) spurious = 1'b1;
        end
        chk("rstmid_no_pulse", spurious, 0);
        lat_b = 0;
        up_b.valid = 4'b0101;
        wait_rdy_b(20, rb, at0);
        chk("rstmid_ptr_zero", rb, 4'b0001);
        up_b.valid[0] = 1'b0;
        wait_rdy_b(20, rb, at1);
        chk("rstmid_next", rb, 4'b0100);
        up_b.valid = '0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
